// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions for the instruction-fetch front end.
// Holds the control-flow opcodes (also used by the decoder), the fetch FSM
// state encoding and small field-extraction helpers.
// Instruction fields: opcode [31:25], cond [24:21], BR pointer register [24:22],
// branch word offset [15:0]. Flag order everywhere is {N,Z,C,V} = bits [3:0],
// so cond bit k tests flag bit k.
package instr_fetch_pkg;

    localparam logic [6:0] OP_B     = 7'b1100000;
    localparam logic [6:0] OP_BCOND = 7'b1100001;
    localparam logic [6:0] OP_BR    = 7'b1100010;
    localparam logic [6:0] OP_HALT  = 7'b1101000;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_HALTED   = 2'd3
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[31:25];
    endfunction

    function automatic logic [2:0] br_reg_of(input logic [31:0] instr);
        return instr[24:22];
    endfunction

    // A condition of 0000 selects no flag and therefore never fires.
    function automatic logic cond_taken(input logic [31:0] instr, input logic [3:0] flags);
        return |(instr[24:21] & flags);
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry registered FIFO carrying {instruction, pc} to the decoder.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes contents)
//   push_i            write request; accepted only when push_ready_o
//   push_data_i       entry to write
//   push_ready_o      fewer than two entries held
//   pop_valid_o       head entry valid
//   pop_data_o        head entry
//   pop_ready_i       consumer takes head when pop_valid_o & pop_ready_i
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid does not depend on ready. Pop while empty is a no-op.
module instr_fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         push_ready_o,
    output logic         pop_valid_o,
    output logic [W-1:0] pop_data_o,
    input  logic         pop_ready_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign push_ready_o = (count_q != 2'd2);
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign do_push      = push_i && push_ready_o;
    assign do_pop       = pop_ready_i && pop_valid_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the PC, issues one word read at a time to
// instruction memory, resolves B/Bcond/BR/HALT locally and hands every other
// instruction with its PC to the decoder through a 2-entry queue.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       read request held until imem_ack; address = pc
//   imem_ack/imem_rdata      read completion and fetched word
//   instr_out/instr_pc       queue head instruction and its byte address
//   instr_valid/instr_ready  queue head handshake (pop when both high)
//   br_reg_addr/br_reg_data  register read for BR target (combinational data)
//   flags                    {N,Z,C,V} from execute
//   exec_idle                nothing in flight downstream of the decoder
//   halted                   HALT retired; fetch stopped until rst
//   dbg_state                current fetch FSM state
// Handshakes: imem_req rises and stays high with a stable address until the
// cycle imem_ack is sampled high; imem_ack in any other state is ignored.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        br_reg_addr,
    input  logic [31:0]       br_reg_data,
    input  logic [3:0]        flags,
    input  logic              exec_idle,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;

    logic                 fifo_push;
    logic                 fifo_push_ready;
    logic [ADDR_W+31:0]   fifo_head;

    logic [31:0]       off_src;
    logic [ADDR_W-1:0] br_ofs;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_plus4;
    logic              unused_bits;

    // One shared target adder: the offset comes from the word being acked
    // (B) or from the latched instruction while resolving (Bcond).
    assign off_src   = (state_q == ST_RESOLVE) ? instr_q : imem_rdata;
    assign br_ofs    = {{(ADDR_W-18){off_src[15]}}, off_src[15:0], 2'b00};
    assign br_target = pc_q + br_ofs;
    assign pc_plus4  = pc_q + ADDR_W'(4);

    assign imem_req  = (state_q == ST_WAIT_MEM);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;
    assign instr_out = fifo_head[ADDR_W+31:ADDR_W];
    assign instr_pc  = fifo_head[ADDR_W-1:0];

    assign unused_bits = ^{br_reg_data[1:0], instr_q[20:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fifo_push   = 1'b0;
        br_reg_addr = 3'd0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (fifo_push_ready) state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                // A request is only issued with a free slot, and the queue can
                // only drain while waiting, so the push below always fits.
                if (imem_ack) begin
                    case (opcode_of(imem_rdata))
                        OP_B: begin
                            pc_d    = br_target;
                            state_d = ST_FETCH;
                        end
                        OP_BCOND, OP_BR: begin
                            instr_d = imem_rdata;
                            state_d = ST_RESOLVE;
                        end
                        OP_HALT: begin
                            state_d = ST_HALTED;
                        end
                        default: begin
                            fifo_push = 1'b1;
                            pc_d      = pc_plus4;
                            state_d   = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_RESOLVE: begin
                br_reg_addr = br_reg_of(instr_q);
                // Flags and the BR register are only trustworthy once every
                // older instruction has left the queue and retired.
                if (!instr_valid && exec_idle) begin
                    state_d = ST_FETCH;
                    if (opcode_of(instr_q) == OP_BR)
                        pc_d = {br_reg_data[ADDR_W-1:2], 2'b00};
                    else if (cond_taken(instr_q, flags))
                        pc_d = br_target;
                    else
                        pc_d = pc_plus4;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    instr_fetch_fifo #(.W(ADDR_W + 32)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .push_data_i  ({imem_rdata, pc_q}),
        .push_ready_o (fifo_push_ready),
        .pop_valid_o  (instr_valid),
        .pop_data_o   (fifo_head),
        .pop_ready_i  (instr_ready)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int ADDR_W = 32;

  localparam logic [31:0] W_MOV  = 32'h0200_0001;
  localparam logic [31:0] W_ADD  = 32'h0400_0002;
  localparam logic [31:0] W_NOP  = 32'h0000_0000;
  localparam logic [31:0] W_HALT = 32'hD000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        br_reg_addr;
  logic [31:0]       br_reg_data;
  logic [3:0]        flags;
  logic              exec_idle;
  logic              halted;
  logic [1:0]        dbg_state;

  instr_fetch #(.ADDR_W(ADDR_W), .PC_RESET(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_reg_addr (br_reg_addr),
    .br_reg_data (br_reg_data),
    .flags       (flags),
    .exec_idle   (exec_idle),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] mem [128];
  logic [31:0] ack_q[$];
  logic [31:0] got_instr_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];

  bit   mem_en  = 1'b1;
  int   mem_lat = 1;
  logic man_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        imem_ack = man_ack;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        if (!rst && imem_req) begin
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr[8:2]];
            ack_q.push_back(imem_addr);
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- decoder sink ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready) begin
        got_instr_q.push_back(instr_out);
        got_pc_q.push_back(instr_pc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = W_HALT;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_q.delete();
    got_instr_q.delete();
    got_pc_q.delete();
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_pc_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nacks"}, 64'(ack_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < ack_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 64'(ack_q[i]), 64'(exp_addr_q[i]));
    check({tag, "_npops"}, 64'(got_instr_q.size()), 64'(exp_instr_q.size()));
    for (int i = 0; i < exp_instr_q.size() && i < got_instr_q.size(); i++) begin
      check($sformatf("%s_instr%0d", tag, i), 64'(got_instr_q[i]), 64'(exp_instr_q[i]));
      check($sformatf("%s_pc%0d", tag, i), 64'(got_pc_q[i]), 64'(exp_pc_q[i]));
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int req_cnt;
    instr_ready = 1'b1;
    br_reg_data = 32'd0;
    flags       = 4'd0;
    exec_idle   = 1'b1;
    fill_mem();

    // T1: reset state, then straight-line MOV, ADD, NOP, HALT
    mem[0] = W_MOV; mem[1] = W_ADD; mem[2] = W_NOP;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_br_addr", 64'(br_reg_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_FETCH));
    check("rst_addr", 64'(imem_addr), 64'd0);
    do_reset();
    exp_addr_q  = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_instr_q = '{W_MOV, W_ADD, W_NOP};
    exp_pc_q    = '{32'h0, 32'h4, 32'h8};
    wait_halted("t1", 60);
    check_stream("t1");

    // T2: decoder stalled 10 cycles -> queue holds exactly two, no requests
    fill_mem();
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("t2_stall_nacks", 64'(ack_q.size()), 64'd2);
    check("t2_stall_valid", 64'(instr_valid), 64'd1);
    check("t2_stall_req", 64'(imem_req), 64'd0);
    check("t2_stall_head", 64'(instr_out), 64'h1111_1111);
    check("t2_stall_head_pc", 64'(instr_pc), 64'h0);
    instr_ready = 1'b1;
    exp_addr_q  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_instr_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    exp_pc_q    = '{32'h0, 32'h4, 32'h8, 32'hC};
    wait_halted("t2", 80);
    check_stream("t2");

    // T3: B +4 at 0 -> 0x10, B 0xFFFC at 0x10 -> 0x00 (now HALT)
    fill_mem();
    mem[0] = 32'hC000_0004;
    mem[4] = 32'hC000_FFFC;
    do_reset();
    n = 0;
    while (ack_q.size() < 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    mem[0] = W_HALT;
    exp_addr_q = '{32'h0, 32'h10, 32'h0};
    wait_halted("t3", 60);
    check_stream("t3");

    // T4a: Bcond Z taken, held by exec_idle=0
    fill_mem();
    mem[0] = 32'hC000_0008;
    mem[8] = 32'hC280_0004;
    flags = 4'b0100;
    exec_idle = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    check("t4a_hold_nacks", 64'(ack_q.size()), 64'd2);
    check("t4a_hold_state", 64'(dbg_state), 64'(ST_RESOLVE));
    check("t4a_hold_req", 64'(imem_req), 64'd0);
    exec_idle = 1'b1;
    exp_addr_q = '{32'h0, 32'h20, 32'h30};
    wait_halted("t4a", 60);
    check_stream("t4a");

    // T4b: same Bcond with flags=N only -> not taken, falls through
    fill_mem();
    mem[0] = 32'hC000_0008;
    mem[8] = 32'hC280_0004;
    mem[9] = 32'h5555_5555;
    flags = 4'b1000;
    do_reset();
    exp_addr_q  = '{32'h0, 32'h20, 32'h24, 32'h28};
    exp_instr_q = '{32'h5555_5555};
    exp_pc_q    = '{32'h24};
    wait_halted("t4b", 60);
    check_stream("t4b");

    // T4c: cond=0000 never taken even with all flags set
    fill_mem();
    mem[0] = 32'hC000_0008;
    mem[8] = 32'hC200_0004;
    flags = 4'b1111;
    do_reset();
    exp_addr_q = '{32'h0, 32'h20, 32'h24};
    wait_halted("t4c", 60);
    check_stream("t4c");
    flags = 4'd0;

    // T5: BR r3 with r3=0x103 -> target 0x100
    fill_mem();
    mem[0] = 32'hC4C0_0000;
    br_reg_data = 32'h0000_0103;
    exec_idle = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    check("t5_state", 64'(dbg_state), 64'(ST_RESOLVE));
    check("t5_br_addr", 64'(br_reg_addr), 64'd3);
    exec_idle = 1'b1;
    exp_addr_q = '{32'h0, 32'h100};
    wait_halted("t5", 60);
    check_stream("t5");
    check("t5_br_addr_after", 64'(br_reg_addr), 64'd0);

    // T6: HALT at 0x8, queue drains, no further requests
    fill_mem();
    mem[0] = 32'h6666_6666; mem[1] = 32'h7777_7777;
    do_reset();
    exp_addr_q  = '{32'h0, 32'h4, 32'h8};
    exp_instr_q = '{32'h6666_6666, 32'h7777_7777};
    exp_pc_q    = '{32'h0, 32'h4};
    wait_halted("t6", 60);
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
    end
    check("t6_req_after_halt", 64'(req_cnt), 64'd0);
    check("t6_state", 64'(dbg_state), 64'(ST_HALTED));
    check_stream("t6");

    // T6b: reset during WAIT_MEM, late ack ignored, queue flushed
    fill_mem();
    mem[0] = 32'h0A0A_0A0A;
    mem[1] = 32'hC000_0003;
    instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (ack_q.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    mem_en = 1'b0;
    repeat (4) @(negedge clk);
    check("t6b_req_held", 64'(imem_req), 64'd1);
    check("t6b_addr_held", 64'(imem_addr), 64'h10);
    check("t6b_valid_before", 64'(instr_valid), 64'd1);
    rst = 1'b1;
    man_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    check("t6b_req_after", 64'(imem_req), 64'd1);
    check("t6b_addr_after", 64'(imem_addr), 64'h0);
    check("t6b_valid_after", 64'(instr_valid), 64'd0);
    ack_q.delete();
    got_instr_q.delete();
    got_pc_q.delete();
    mem[0] = W_HALT;
    mem_en = 1'b1;
    instr_ready = 1'b1;
    exp_addr_q  = '{32'h0};
    exp_instr_q.delete();
    exp_pc_q.delete();
    wait_halted("t6b", 40);
    check_stream("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
